packet_demux: RTL and testbench
===============================

# packet_demux

Datapath stage directly downstream of the serial packet controller. Using the controller's state, it deserializes the packet on `serIn`:
- 2-bit destination port, then 4-bit byte count, then byte-count × 8 data bits.
- Each completed byte is presented on a shared bus with a one-hot per-port strobe.
- End of packet is flagged, and length mismatches or aborts are reported.

## Interface
Parameters:
- `NPORTS`, 4, number of destination ports (fixed 4; port field is 2 bits)
- `S0/S1/S2/S3`, 2'b00/2'b01/2'b10/2'b11, controller state encoding (idle / port field / length field / data)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `serIn`  in  1  serial packet bit stream (same wire the controller sees)
- `state`  in  2  controller state; changes on falling edge of `clk`
- `outValid`  in  1  controller data-phase flag; high during S1–S3
- `port`  out  2  latched destination port of the current/last packet
- `byteCount`  out  4  latched length field of the current/last packet
- `dataOut`  out  8  last completed data byte, MSB first
- `dataValid`  out  4  one-hot strobe, bit `port` high for 1 cycle per delivered byte
- `packetDone`  out  1  1-cycle pulse at packet end
- `lenError`  out  1  sticky error flag, cleared at next packet start

## Operation
- `serIn` is sampled on the rising edge. `state` is stable there because it changes on the falling edge.
- All fields arrive MSB first.
- Internal registers:
  - `prevState` (2b)
  - bit counter `bitCnt` (3b)
  - shift register `sh` (8b)
  - received-byte counter `rxBytes` (5b, saturating at 16)
- **S1**: `port <= {port[0], serIn}` for 2 cycles.
- **S2**: `byteCount <= {byteCount[2:0], serIn}` for 4 cycles.
- **Packet start** (`prevState==S0 && state==S1`):
  - clear `bitCnt`, `rxBytes` and `lenError`.
  - the same cycle's S1 bit is shifted into `port`.
- **S3**: `sh <= {sh[6:0], serIn}`, `bitCnt++` (wraps 7→0).
  - When `bitCnt==7`:
    - `dataOut <= {sh[6:0], serIn}`
    - `rxBytes++`
    - if `rxBytes < byteCount`: `dataValid[port] <= 1` for exactly one cycle
    - otherwise: byte discarded, no strobe, `lenError <= 1`
- **Packet end** (`prevState==S3 && state==S0`):
  - `packetDone <= 1` for one cycle.
  - `lenError <= 1` if `bitCnt!=0` (partial byte discarded) or `rxBytes != byteCount`.
- **Abort** (`prevState` in {S1,S2} and `state==S0`): `lenError <= 1`, no `packetDone`, no strobe.
- `outValid` low while `state` is in S1–S3 is treated as abort.
- `byteCount==0` followed by any S3 cycles: no bytes delivered, `lenError` set at end.
- Arithmetic: `rxBytes` compared zero-extended against `byteCount`. It saturates at 16, so overflow never wraps to a valid count.

## Timing
- Reset (`reset==0`, asynchronous): all outputs 0, `prevState=S0`, counters and `sh` cleared. Takes effect immediately.
- Reset mid-packet: in-flight byte dropped, no strobe, no `packetDone`. After release, the block waits for the next S0→S1.
- Latency: `dataValid`/`dataOut` update on the rising edge that samples the 8th bit of a byte. `dataOut` holds until the next byte.
- `packetDone` asserts on the first rising edge with `state==S0` after S3.
- S1 spans 2 cycles, S2 spans 4, S3 spans `byteCount`×8.
- Strobes of consecutive bytes are exactly 8 cycles apart.
- Simultaneous byte completion and packet end cannot occur: the final bit is sampled in S3, and end is detected one cycle later.
- `port`/`byteCount` remain stable from end of S2 until the next packet's S1.

## Test plan
- **Reset:** assert `reset=0` mid-S3 after 5 data bits -> all outputs 0 immediately; no `dataValid` or `packetDone` follows until a new packet.
- **Single byte:** port=2'b10, len=4'd1, data 8'hA5 -> `dataOut=8'hA5` and `dataValid=4'b0100` for one cycle on the 8th data bit; `packetDone` next cycle; `lenError=0`.
- **Two bytes:** port=3, len=2, data 8'h3C, 8'hFF -> strobes `4'b1000` with `8'h3C` then `8'hFF`, 8 cycles apart; `packetDone` 1 cycle after the last strobe; `lenError=0`.
- **Short packet:** len=2 but S3 lasts 12 cycles -> one strobe only; the 4-bit partial byte is discarded; `packetDone=1` and `lenError=1`.
- **Long and empty packets:**
  - len=1 but S3 lasts 16 cycles -> one strobe; the second byte updates `dataOut` with no strobe; `lenError=1`.
  - len=0 with 8 S3 cycles -> no strobe; `lenError=1`.
- **Abort and recovery:** `state` returns S2→S0 after 2 length bits -> `lenError=1`, no `packetDone`. The next valid packet (port=0, len=1, 8'h01) clears `lenError` at S1 and strobes `4'b0001`.

Source files
------------

// File: rtl/packet_demux_if.sv
// Serial packet bus between the packet controller and the demux stage.
// The master drives the serial stream and controller state; the slave returns the demuxed byte stream.
interface packet_demux_if;
  logic       serIn;
  logic [1:0] state;
  logic       outValid;
  logic [1:0] port;
  logic [3:0] byteCount;
  logic [7:0] dataOut;
  logic [3:0] dataValid;
  logic       packetDone;
  logic       lenError;

  modport master (
    output serIn, state, outValid,
    input  port, byteCount, dataOut, dataValid, packetDone, lenError
  );

  modport slave (
    input  serIn, state, outValid,
    output port, byteCount, dataOut, dataValid, packetDone, lenError
  );
endinterface

// File: rtl/packet_demux.sv
// Deserializes port/length/data fields, following the controller state, onto a shared byte bus.
// Each delivered byte raises a one-hot per-port strobe; length mismatches and aborts raise a sticky error.
module packet_demux #(
  parameter int         NPORTS = 4,
  parameter logic [1:0] S0     = 2'b00,
  parameter logic [1:0] S1     = 2'b01,
  parameter logic [1:0] S2     = 2'b10,
  parameter logic [1:0] S3     = 2'b11
) (
  input  logic          clk,
  input  logic          reset,
  packet_demux_if.slave bus
);

  typedef enum logic {PH_WAIT = 1'b0, PH_PKT = 1'b1} phase_t;

  phase_t              r_phase, w_phase_nxt;
  logic [1:0]          r_prev_state;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]          r_sh, w_sh_nxt;
  logic [4:0]          r_rx_bytes, w_rx_bytes_nxt;
  logic [1:0]          r_port, w_port_nxt;
  logic [3:0]          r_byte_count, w_byte_count_nxt;
  logic [7:0]          r_data_out, w_data_out_nxt;
  logic [NPORTS-1:0]   r_data_valid, w_data_valid_nxt;
  logic                r_packet_done, w_packet_done_nxt;
  logic                r_len_error, w_len_error_nxt;

  logic                w_ov_abort;
  logic [1:0]          w_eff_state;
  logic                w_start;
  logic                w_in_pkt;

  // Next-state and output decode, driven by the controller state seen at this rising edge
  always_comb begin
    // outValid dropping mid-packet is folded into an early return to idle
    w_ov_abort        = (bus.state != S0) && !bus.outValid;
    w_eff_state       = w_ov_abort ? S0 : bus.state;
    w_start           = (r_prev_state == S0) && (w_eff_state == S1);
    w_in_pkt          = (r_phase == PH_PKT);

    w_phase_nxt       = r_phase;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_sh_nxt          = r_sh;
    w_rx_bytes_nxt    = r_rx_bytes;
    w_port_nxt        = r_port;
    w_byte_count_nxt  = r_byte_count;
    w_data_out_nxt    = r_data_out;
    w_data_valid_nxt  = '0;
    w_packet_done_nxt = 1'b0;
    w_len_error_nxt   = r_len_error;

    if (w_start) begin
      w_phase_nxt     = PH_PKT;
      w_bit_cnt_nxt   = 3'd0;
      w_rx_bytes_nxt  = 5'd0;
      w_len_error_nxt = 1'b0;
    end else begin
      w_phase_nxt     = r_phase;
    end

    case (w_eff_state)
      S1: begin
        if (w_start || w_in_pkt) begin
          w_port_nxt = {r_port[0], bus.serIn};
        end else begin
          w_port_nxt = r_port;
        end
      end
      S2: begin
        if (w_in_pkt) begin
          w_byte_count_nxt = {r_byte_count[2:0], bus.serIn};
        end else begin
          w_byte_count_nxt = r_byte_count;
        end
      end
      S3: begin
        if (w_in_pkt) begin
          w_sh_nxt      = {r_sh[6:0], bus.serIn};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_data_out_nxt = {r_sh[6:0], bus.serIn};
            w_rx_bytes_nxt = (r_rx_bytes == 5'd16) ? r_rx_bytes : r_rx_bytes + 5'd1;
            if (r_rx_bytes < {1'b0, r_byte_count}) begin
              w_data_valid_nxt = NPORTS'(1) << r_port;
            end else begin
              w_len_error_nxt  = 1'b1;
            end
          end else begin
            w_data_out_nxt = r_data_out;
          end
        end else begin
          w_sh_nxt = r_sh;
        end
      end
      S0: begin
        if (w_in_pkt) begin
          w_phase_nxt = PH_WAIT;
          if ((r_prev_state == S3) && !w_ov_abort) begin
            w_packet_done_nxt = 1'b1;
            if ((r_bit_cnt != 3'd0) || (r_rx_bytes != {1'b0, r_byte_count})) begin
              w_len_error_nxt = 1'b1;
            end else begin
              w_len_error_nxt = r_len_error;
            end
          end else begin
            w_len_error_nxt = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase;
        end
      end
      default: begin
        w_phase_nxt = r_phase;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase       <= PH_WAIT;
      r_prev_state  <= S0;
      r_bit_cnt     <= 3'd0;
      r_sh          <= 8'd0;
      r_rx_bytes    <= 5'd0;
      r_port        <= 2'd0;
      r_byte_count  <= 4'd0;
      r_data_out    <= 8'd0;
      r_data_valid  <= '0;
      r_packet_done <= 1'b0;
      r_len_error   <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_prev_state  <= w_eff_state;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_sh          <= w_sh_nxt;
      r_rx_bytes    <= w_rx_bytes_nxt;
      r_port        <= w_port_nxt;
      r_byte_count  <= w_byte_count_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_packet_done <= w_packet_done_nxt;
      r_len_error   <= w_len_error_nxt;
    end
  end

  assign bus.port       = r_port;
  assign bus.byteCount  = r_byte_count;
  assign bus.dataOut    = r_data_out;
  assign bus.dataValid  = r_data_valid;
  assign bus.packetDone = r_packet_done;
  assign bus.lenError   = r_len_error;

endmodule

// File: tb/tb_packet_demux.sv
// Bench for packet_demux: directed packet table, reset mid-packet, then random packets,
// each checked cycle by cycle against a packet-level model of the expected byte stream.
module tb_packet_demux;

  typedef struct {
    logic [1:0] port;
    logic [3:0] len;
    int         n;          // S3 cycles
    int         abort_at;   // packet cycle where the abort happens, 0 = none
    bit         ov_abort;   // abort by dropping outValid instead of returning to S0
    logic [7:0] d0;
    logic [7:0] d1;
    int         exp_strobes;
    bit         exp_err;
    bit         exp_done;
  } pkt_t;

  logic clk;
  logic reset;
  packet_demux_if bus ();

  packet_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  logic [7:0] exp_dout;
  logic       exp_err;
  pkt_t       tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_packet(input pkt_t p, input bit use_tbl);
    logic [7:0] d[20];
    logic [3:0] exp_dv;
    int         end_c;
    int         i;
    int         act_strobes;
    bit         done_seen;
    for (int k = 0; k < 20; k++) d[k] = 8'($urandom);
    d[0] = p.d0;
    d[1] = p.d1;
    end_c = 7 + p.n;
    act_strobes = 0;
    done_seen = 1'b0;
    for (int c = 0; c < end_c + 2; c++) begin
      logic [1:0] st;
      logic       ov;
      logic       b;
      logic       exp_pd;
      st = 2'b00; ov = 1'b0; b = 1'($urandom);
      exp_dv = 4'b0000; exp_pd = 1'b0;
      if (p.abort_at != 0 && c >= p.abort_at) begin
        if (c == p.abort_at && p.ov_abort) begin
          st = 2'b10; ov = 1'b0;
        end
        if (c == p.abort_at) exp_err = 1'b1;
      end else if (c >= 1 && c <= 2) begin
        st = 2'b01; ov = 1'b1; b = p.port[2 - c];
        if (c == 1) exp_err = 1'b0;
      end else if (c >= 3 && c <= 6) begin
        st = 2'b10; ov = 1'b1; b = p.len[6 - c];
      end else if (c >= 7 && c < end_c) begin
        st = 2'b11; ov = 1'b1;
        i = c - 7;
        b = d[i / 8][7 - (i % 8)];
        if (i % 8 == 7) begin
          exp_dout = d[i / 8];
          if (i / 8 < int'(p.len)) exp_dv = 4'b0001 << p.port;
          else exp_err = 1'b1;
        end
      end else if (c == end_c) begin
        exp_pd = 1'b1;
        if ((p.n % 8 != 0) || (p.n / 8 != int'(p.len))) exp_err = 1'b1;
      end
      bus.state = st; bus.outValid = ov; bus.serIn = b;
      @(negedge clk);
      chk("dataValid", 32'(bus.dataValid), 32'(exp_dv));
      chk("dataOut", 32'(bus.dataOut), 32'(exp_dout));
      chk("packetDone", 32'(bus.packetDone), 32'(exp_pd));
      chk("lenError", 32'(bus.lenError), 32'(exp_err));
      if (c >= 7 && p.abort_at == 0) begin
        chk("port", 32'(bus.port), 32'(p.port));
        chk("byteCount", 32'(bus.byteCount), 32'(p.len));
      end
      if (bus.dataValid != 4'b0000) act_strobes++;
      if (bus.packetDone) done_seen = 1'b1;
    end
    if (use_tbl) begin
      chk("tbl_strobes", 32'(act_strobes), 32'(p.exp_strobes));
      chk("tbl_lenError", 32'(bus.lenError), 32'(p.exp_err));
      chk("tbl_done", 32'(done_seen), 32'(p.exp_done));
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_port"}, 32'(bus.port), 32'd0);
    chk({nm, "_byteCount"}, 32'(bus.byteCount), 32'd0);
    chk({nm, "_dataOut"}, 32'(bus.dataOut), 32'd0);
    chk({nm, "_dataValid"}, 32'(bus.dataValid), 32'd0);
    chk({nm, "_packetDone"}, 32'(bus.packetDone), 32'd0);
    chk({nm, "_lenError"}, 32'(bus.lenError), 32'd0);
  endtask

  initial begin
    pkt_t       rp;
    logic [1:0] rs_port;
    logic [3:0] rs_len;
    n_checks = 0; n_errors = 0;
    exp_dout = 8'h00; exp_err = 1'b0;
    clk = 1'b0; reset = 1'b0;
    bus.serIn = 1'b0; bus.state = 2'b00; bus.outValid = 1'b0;

    //          port   len    n   ab ov  d0     d1     str err done
    tbl[0] = '{2'd2, 4'd1,  8, 0, 0, 8'hA5, 8'h00, 1, 0, 1}; // single byte
    tbl[1] = '{2'd3, 4'd2, 16, 0, 0, 8'h3C, 8'hFF, 2, 0, 1}; // two bytes
    tbl[2] = '{2'd1, 4'd2, 12, 0, 0, 8'h5A, 8'h77, 1, 1, 1}; // short
    tbl[3] = '{2'd0, 4'd1, 16, 0, 0, 8'hC3, 8'h96, 1, 1, 1}; // long
    tbl[4] = '{2'd2, 4'd0,  8, 0, 0, 8'h81, 8'h00, 0, 1, 1}; // empty
    tbl[5] = '{2'd1, 4'd5,  0, 5, 0, 8'h00, 8'h00, 0, 1, 0}; // abort in S2
    tbl[6] = '{2'd0, 4'd1,  8, 0, 0, 8'h01, 8'h00, 1, 0, 1}; // recovery
    tbl[7] = '{2'd3, 4'd3,  0, 2, 1, 8'h00, 8'h00, 0, 1, 0}; // outValid drop
    tbl[8] = '{2'd1, 4'd3, 24, 0, 0, 8'hE7, 8'h18, 3, 0, 1}; // recovery, 3 bytes

    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++) run_packet(tbl[t], 1'b1);

    // Reset mid-S3 after 5 data bits of a port=1 len=2 packet
    rs_port = 2'd1; rs_len = 4'd2;
    for (int c = 1; c <= 11; c++) begin
      bus.outValid = 1'b1;
      if (c <= 2) begin
        bus.state = 2'b01; bus.serIn = rs_port[2 - c];
      end else if (c <= 6) begin
        bus.state = 2'b10; bus.serIn = rs_len[6 - c];
      end else begin
        bus.state = 2'b11; bus.serIn = 1'($urandom);
      end
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.state = (c < 11) ? 2'b11 : 2'b00;
      bus.outValid = (c < 11);
      bus.serIn = 1'($urandom);
      @(negedge clk);
      chk("postreset_dataValid", 32'(bus.dataValid), 32'd0);
      chk("postreset_packetDone", 32'(bus.packetDone), 32'd0);
    end
    exp_dout = 8'h00; exp_err = 1'b0;
    run_packet(tbl[6], 1'b1);

    // Random packets
    for (int k = 0; k < 40; k++) begin
      rp.port = 2'($urandom);
      rp.len  = 4'($urandom);
      if ($urandom_range(0, 3) != 0) rp.n = (rp.len == 4'd0) ? 8 : 8 * int'(rp.len);
      else rp.n = $urandom_range(1, 8 * int'(rp.len) + 12);
      rp.abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 6) : 0;
      rp.ov_abort = 1'($urandom);
      rp.d0 = 8'($urandom);
      rp.d1 = 8'($urandom);
      rp.exp_strobes = 0; rp.exp_err = 1'b0; rp.exp_done = 1'b0;
      run_packet(rp, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
